// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver with a 2-flop line synchroniser,
// 3-sample majority voting, and registered per-frame error reporting.
// Ports:
//   clk, rst          single clock, asynchronous active-high reset
//   RX_IN             serial line (idle high, asynchronous to clk)
//   Prescale          oversampling ratio (even, >= 8), captured at frame start
//   PAR_EN, PAR_TYP   parity enable / type (0 even, 1 odd), captured at frame start
//   STOP2             two stop bits expected, captured at frame start
//   P_DATA            data of the last good frame
//   data_valid        1-cycle pulse when P_DATA is updated with a good frame
//   par_err, frm_err  1-cycle pulses reporting parity / stop-bit errors
module uart_rx_param #(
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned PRESC_W = 6
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               RX_IN,
   input  logic [PRESC_W-1:0] Prescale,
   input  logic               PAR_EN,
   input  logic               PAR_TYP,
   input  logic               STOP2,
   output logic [DATA_W-1:0]  P_DATA,
   output logic               data_valid,
   output logic               par_err,
   output logic               frm_err
);

   typedef enum logic [2:0] {
      IDLE, START, DATA, PARITY, STOP, STOP_2, DONE
   } state_t;

   state_t             state;
   logic [1:0]         sync;
   logic               rx_s;
   logic [PRESC_W-1:0] edge_cnt;
   logic [PRESC_W-1:0] presc_r;
   logic [PRESC_W-1:0] half;
   logic [3:0]         bit_cnt;
   logic               par_en_r;
   logic               par_typ_r;
   logic               stop2_r;
   logic [2:0]         samp;
   logic [DATA_W-1:0]  shreg;
   logic               err_p;
   logic               err_f;
   logic               at_last;
   logic               bit_v;
   logic               counting;

   assign rx_s     = sync[1];
   assign half     = presc_r >> 1;
   assign at_last  = (edge_cnt == presc_r - PRESC_W'(1));
   assign bit_v    = (samp[0] & samp[1]) | (samp[0] & samp[2]) | (samp[1] & samp[2]);
   assign counting = (state != IDLE) && (state != DONE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         sync       <= 2'b11;
         edge_cnt   <= '0;
         presc_r    <= '0;
         bit_cnt    <= '0;
         par_en_r   <= 1'b0;
         par_typ_r  <= 1'b0;
         stop2_r    <= 1'b0;
         samp       <= '0;
         shreg      <= '0;
         err_p      <= 1'b0;
         err_f      <= 1'b0;
         P_DATA     <= '0;
         data_valid <= 1'b0;
         par_err    <= 1'b0;
         frm_err    <= 1'b0;
      end else begin
         sync       <= {sync[0], RX_IN};
         data_valid <= 1'b0;
         par_err    <= 1'b0;
         frm_err    <= 1'b0;

         // Bit-period timing and mid-bit sampling, active while a bit is being received
         if (counting) begin
            if (edge_cnt == half - PRESC_W'(1)) samp[0] <= rx_s;
            if (edge_cnt == half)               samp[1] <= rx_s;
            if (edge_cnt == half + PRESC_W'(1)) samp[2] <= rx_s;
            if (at_last) begin
               edge_cnt <= '0;
               bit_cnt  <= 4'(bit_cnt + 4'd1);
            end else begin
               edge_cnt <= edge_cnt + PRESC_W'(1);
            end
         end

         case (state)
            IDLE: begin
               if (!rx_s) begin
                  state     <= START;
                  presc_r   <= Prescale;
                  par_en_r  <= PAR_EN;
                  par_typ_r <= PAR_TYP;
                  stop2_r   <= STOP2;
                  err_p     <= 1'b0;
                  err_f     <= 1'b0;
               end
            end
            START: begin
               if (at_last) begin
                  if (bit_v) begin
                     // false start: back to idle with counters cleared
                     state    <= IDLE;
                     edge_cnt <= '0;
                     bit_cnt  <= '0;
                  end else begin
                     state <= DATA;
                  end
               end
            end
            DATA: begin
               if (at_last) begin
                  shreg <= {bit_v, shreg[DATA_W-1:1]};
                  // bit_cnt is 1 on the first data bit (the start bit wrapped once)
                  if (bit_cnt == 4'(DATA_W)) state <= par_en_r ? PARITY : STOP;
               end
            end
            PARITY: begin
               if (at_last) begin
                  err_p <= (^shreg) ^ bit_v ^ par_typ_r;
                  state <= STOP;
               end
            end
            STOP: begin
               if (at_last) begin
                  if (!bit_v) err_f <= 1'b1;
                  state <= stop2_r ? STOP_2 : DONE;
               end
            end
            STOP_2: begin
               if (at_last) begin
                  if (!bit_v) err_f <= 1'b1;
                  state <= DONE;
               end
            end
            DONE: begin
               if (!err_p && !err_f) begin
                  P_DATA     <= shreg;
                  data_valid <= 1'b1;
               end
               par_err  <= err_p;
               frm_err  <= err_f;
               state    <= IDLE;
               edge_cnt <= '0;
               bit_cnt  <= '0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: self-checking bench for uart_rx_param (DATA_W=8 and DATA_W=5 builds).
// Frames are built bit by bit on the line; every reported pulse is captured into a queue
// and compared against expected events from a table or a frame-level reference model.
module tb_uart_rx_param;
   localparam int unsigned PW = 6;

   typedef struct packed {
      logic       dv;
      logic       pe;
      logic       fe;
      logic [8:0] pd;
   } ev_t;

   typedef struct {
      logic [8:0] d;
      int         p;
      bit         pe, pt, s2, pflip, bad1, bad2;
      logic       x_dv, x_pe, x_fe;
      logic [8:0] x_pd;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          rx8, rx5;
   logic [PW-1:0] presc;
   logic          par_en, par_typ, stop2;
   logic [7:0]    pd8;
   logic          dv8, pe8, fe8;
   logic [4:0]    pd5;
   logic          dv5, pe5, fe5;

   int  tests = 0;
   int  fails = 0;
   bit  sel5  = 1'b0;
   ev_t got[$];
   ev_t exp_q[$];
   logic [8:0] last8 = '0;
   logic [8:0] last5 = '0;
   vec_t tbl[8];

   always #5 clk = ~clk;

   uart_rx_param #(.DATA_W(8), .PRESC_W(PW)) dut8 (
      .clk(clk), .rst(rst), .RX_IN(rx8), .Prescale(presc), .PAR_EN(par_en),
      .PAR_TYP(par_typ), .STOP2(stop2), .P_DATA(pd8), .data_valid(dv8),
      .par_err(pe8), .frm_err(fe8));

   uart_rx_param #(.DATA_W(5), .PRESC_W(PW)) dut5 (
      .clk(clk), .rst(rst), .RX_IN(rx5), .Prescale(presc), .PAR_EN(par_en),
      .PAR_TYP(par_typ), .STOP2(stop2), .P_DATA(pd5), .data_valid(dv5),
      .par_err(pe5), .frm_err(fe5));

   // Capture every output pulse of the selected receiver
   always @(negedge clk) begin
      if (!sel5 && (dv8 || pe8 || fe8)) got.push_back({dv8, pe8, fe8, 1'b0, pd8});
      if (sel5 && (dv5 || pe5 || fe5))  got.push_back({dv5, pe5, fe5, 4'b0, pd5});
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   task automatic set_rx(input logic b);
      if (sel5) rx5 = b;
      else      rx8 = b;
   endtask

   // One bit on the line for p clocks; optional single-cycle inversion near mid-bit
   task automatic send_bit(input logic b, input int p, input bit glitch);
      for (int i = 0; i < p; i++) begin
         @(negedge clk);
         set_rx((glitch && i == p / 2 + 2) ? ~b : b);
      end
   endtask

   task automatic send_frame(input logic [8:0] d, input int nd, input int p, input bit pe,
                             input bit pt, input bit s2, input bit pflip, input bit bad1,
                             input bit bad2, input bit glitch, input bit scramble,
                             input int gap);
      logic par;
      presc   = PW'(p);
      par_en  = pe;
      par_typ = pt;
      stop2   = s2;
      send_bit(1'b0, p, glitch);
      if (scramble) begin
         presc   = PW'($urandom);
         par_en  = 1'($urandom);
         par_typ = 1'($urandom);
         stop2   = 1'($urandom);
      end
      par = pt ^ pflip;
      for (int i = 0; i < nd; i++) begin
         send_bit(d[i], p, glitch);
         par ^= d[i];
      end
      if (pe) send_bit(par, p, glitch);
      send_bit(!bad1, p, glitch);
      if (s2) send_bit(!bad2, p, glitch);
      for (int i = 0; i < gap; i++) begin
         @(negedge clk);
         set_rx(1'b1);
      end
   endtask

   // Frame-level reference: expected pulse from the frame's error content
   task automatic model_push(input logic [8:0] d, input int nd, input bit pe, input bit pflip,
                             input bit s2, input bit bad1, input bit bad2);
      ev_t e;
      logic [8:0] dm;
      dm   = d & (9'(1 << nd) - 9'd1);
      e.pe = pe & pflip;
      e.fe = bad1 | (s2 & bad2);
      e.dv = !(e.pe || e.fe);
      if (e.dv) begin
         if (sel5) last5 = dm;
         else      last8 = dm;
      end
      e.pd = sel5 ? last5 : last8;
      exp_q.push_back(e);
   endtask

   task automatic check_events(input string name);
      ev_t g, e;
      int  n;
      repeat (8) @(negedge clk);
      #1;
      chk({name, "_count"}, 32'(got.size()), 32'(exp_q.size()));
      n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
      for (int k = 0; k < n; k++) begin
         g = got.pop_front();
         e = exp_q.pop_front();
         chk($sformatf("%s_ev%0d", name, k), 32'(g), 32'(e));
      end
      got.delete();
      exp_q.delete();
   endtask

   initial begin
      rst = 1'b1; rx8 = 1'b1; rx5 = 1'b1;
      presc = PW'(8); par_en = 1'b0; par_typ = 1'b0; stop2 = 1'b0;

      // d, P, pe, pt, s2, pflip, bad1, bad2 -> dv, pe, fe, P_DATA
      tbl[0] = '{9'h0A5, 8,  0, 0, 0, 0, 0, 0, 1, 0, 0, 9'h0A5};
      tbl[1] = '{9'h03C, 8,  1, 0, 0, 0, 0, 0, 1, 0, 0, 9'h03C};
      tbl[2] = '{9'h03C, 8,  1, 0, 0, 1, 0, 0, 0, 1, 0, 9'h03C};
      tbl[3] = '{9'h081, 8,  0, 0, 1, 0, 0, 1, 0, 0, 1, 9'h03C};
      tbl[4] = '{9'h081, 8,  0, 0, 1, 0, 0, 0, 1, 0, 0, 9'h081};
      tbl[5] = '{9'h05A, 16, 1, 1, 0, 0, 0, 0, 1, 0, 0, 9'h05A};
      tbl[6] = '{9'h00F, 16, 1, 1, 1, 1, 1, 0, 0, 1, 1, 9'h05A};
      tbl[7] = '{9'h000, 32, 0, 0, 0, 0, 0, 0, 1, 0, 0, 9'h000};

      repeat (3) @(negedge clk);
      chk("reset_out8", {28'd0, dv8, pe8, fe8, 1'b0}, 32'd0);
      chk("reset_pd8", 32'(pd8), 32'd0);
      chk("reset_out5", {24'd0, dv5, pe5, fe5, pd5}, 32'd0);
      rst = 1'b0;
      repeat (4) @(negedge clk);

      // Directed table
      for (int i = 0; i < 8; i++) begin
         send_frame(tbl[i].d, 8, tbl[i].p, tbl[i].pe, tbl[i].pt, tbl[i].s2, tbl[i].pflip,
                    tbl[i].bad1, tbl[i].bad2, 1'b0, 1'b1, 2 * tbl[i].p);
         exp_q.push_back({tbl[i].x_dv, tbl[i].x_pe, tbl[i].x_fe, tbl[i].x_pd});
         if (tbl[i].x_dv) last8 = tbl[i].x_pd;
         check_events($sformatf("tbl%0d", i));
      end

      // Short low pulse is a false start: no pulses, receiver still works afterwards
      presc = PW'(16);
      repeat (4) begin @(negedge clk); set_rx(1'b0); end
      repeat (48) begin @(negedge clk); set_rx(1'b1); end
      check_events("false_start");
      send_frame(9'h0C3, 8, 16, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 32);
      model_push(9'h0C3, 8, 0, 0, 0, 0, 0);
      check_events("after_false_start");

      // Back-to-back frames with one inverted sample per bit
      send_frame(9'h055, 8, 16, 0, 0, 0, 0, 0, 0, 1'b1, 1'b0, 0);
      model_push(9'h055, 8, 0, 0, 0, 0, 0);
      send_frame(9'h0AA, 8, 16, 0, 0, 0, 0, 0, 0, 1'b1, 1'b0, 0);
      model_push(9'h0AA, 8, 0, 0, 0, 0, 0);
      send_frame(9'h0FF, 8, 16, 0, 0, 0, 0, 0, 0, 1'b1, 1'b0, 48);
      model_push(9'h0FF, 8, 0, 0, 0, 0, 0);
      check_events("b2b_vote");

      // Reset in the middle of the data bits
      presc = PW'(8); par_en = 1'b0; stop2 = 1'b0;
      send_bit(1'b0, 8, 1'b0);
      send_bit(1'b1, 8, 1'b0);
      send_bit(1'b0, 8, 1'b0);
      send_bit(1'b1, 8, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      set_rx(1'b1);
      repeat (3) @(negedge clk);
      chk("rst_mid_out", {28'd0, dv8, pe8, fe8, 1'b0}, 32'd0);
      chk("rst_mid_pd", 32'(pd8), 32'd0);
      rst = 1'b0;
      last8 = '0;
      repeat (20) @(negedge clk);
      check_events("rst_no_ev");
      send_frame(9'h012, 8, 8, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 16);
      model_push(9'h012, 8, 0, 0, 0, 0, 0);
      check_events("after_rst");

      // 5-bit build
      sel5 = 1'b1;
      send_frame(9'h015, 5, 8, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 16);
      model_push(9'h015, 5, 0, 0, 0, 0, 0);
      check_events("dw5_15");
      sel5 = 1'b0;

      // Randomised frames against the frame-level model
      for (int i = 0; i < 24; i++) begin
         int p, nd;
         bit pe, pt, s2, pflip, bad1, bad2, gl;
         logic [8:0] d;
         sel5  = (i % 4 == 3);
         nd    = sel5 ? 5 : 8;
         p     = 8 << $urandom_range(0, 2);
         d     = 9'($urandom);
         pe    = 1'($urandom);
         pt    = 1'($urandom);
         s2    = 1'($urandom);
         pflip = pe && ($urandom_range(0, 3) == 0);
         bad1  = ($urandom_range(0, 4) == 0);
         bad2  = s2 && ($urandom_range(0, 4) == 0);
         gl    = (p >= 16) && 1'($urandom);
         send_frame(d, nd, p, pe, pt, s2, pflip, bad1, bad2, gl, 1'b1,
                    p + $urandom_range(0, p - 1));
         model_push(d, nd, pe, pflip, s2, bad1, bad2);
         check_events($sformatf("rnd%0d", i));
      end
      sel5 = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
